pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Consumer of the ID-stage hazard flag and the MEM-stage SRAM handshake. It turns them, together with the EXE-stage branch decision, into per-stage freeze, flush and bubble controls for the MIPS five-stage pipeline registers and PC. It sits beside the hazard detection unit in the top-level datapath. It holds a small FSM for multi-cycle memory waits, with a watchdog, plus saturating performance counters.

## Interface
- `MEM_TIMEOUT`, default 64: consecutive memory-wait cycles before the watchdog error sets.
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `hazard_detected` in 1: RAW hazard flag from the hazard detection unit; the ID instruction must stall.
- `branch_taken` in 1: EXE-stage branch or jump resolved taken.
- `mem_access` in 1: MEM-stage instruction reads or writes SRAM.
- `mem_ready` in 1: SRAM controller has completed the current access.
- `pc_freeze` out 1: hold the PC.
- `if_id_freeze` out 1: hold the IF/ID register.
- `if_id_flush` out 1: load a NOP into IF/ID.
- `id_ex_freeze` out 1: hold the ID/EX register.
- `id_ex_bubble` out 1: load a NOP (all enables 0) into ID/EX.
- `ex_mem_freeze` out 1: hold the EX/MEM register.
- `mem_wb_freeze` out 1: hold the MEM/WB register.
- `mem_timeout_err` out 1: sticky watchdog error.
- `stall_cycles` out `CNT_W`: cycles with a hazard stall applied.
- `flush_events` out `CNT_W`: taken-branch flushes applied.
- `mem_wait_cycles` out `CNT_W`: cycles spent in a memory freeze.

## Operation
- FSM states are RUN and MEM_WAIT. Reset state is RUN.
- RUN to MEM_WAIT when `mem_access & ~mem_ready`.
- MEM_WAIT to RUN when `mem_ready`. `mem_access` is ignored in MEM_WAIT.
- A memory freeze (`mem_freeze`) is active when in RUN with `mem_access & ~mem_ready`, or in MEM_WAIT with `~mem_ready`.
- Control priority, highest first:
  1. `mem_freeze`: all five freeze outputs are 1. Flush and bubble are 0. `branch_taken` and `hazard_detected` are ignored, because the instructions are re-presented after release.
  2. `branch_taken`: `if_id_flush` = 1 and `id_ex_bubble` = 1. All freezes are 0, so the PC loads the target. A coincident hazard is discarded, because its instruction is on the wrong path.
  3. `hazard_detected`: `pc_freeze`, `if_id_freeze` and `id_ex_bubble` are 1. All other outputs are 0.
  4. Otherwise all control outputs are 0.
- Control outputs are combinational from the FSM state and the inputs. They are forced to 0 while `rst` is high.
- Watchdog:
  - `wait_cnt` clears on entry to MEM_WAIT and increments each MEM_WAIT cycle with `~mem_ready`.
  - When `wait_cnt` reaches `MEM_TIMEOUT-1`, `mem_timeout_err` sets on the next edge.
  - The error stays set until `rst`. The pipeline stays frozen; there is no forced release.
  - `wait_cnt` saturates.
- Counters:
  - Each counter increments by 1 on every clock edge where its condition (case 3, case 2, or `mem_freeze`) held.
  - Counters saturate at all-ones and never wrap.

## Timing
- Zero-latency control: outputs respond in the same cycle as their inputs.
- FSM, watchdog and counters update on the rising edge of `clk`.
- Zero-wait access (`mem_access & mem_ready` in RUN): no freeze, and the FSM stays in RUN.
- An N-cycle SRAM access freezes the pipeline for exactly N-1 cycles. The release cycle (`mem_ready` = 1) has the freeze deasserted, so MEM/WB captures that cycle.
- A `branch_taken` that is held during a freeze takes effect in the release cycle.
- Reset asserted mid-wait:
  - State returns to RUN and `wait_cnt` clears.
  - Counters and `mem_timeout_err` go to 0 immediately (asynchronous).
  - All outputs are 0 from the reset assertion onward.

## Structure
- The shared package holds:
  - the state enum (`ST_RUN`, `ST_MEM_WAIT`);
  - the default `CNT_W`;
  - the NOP/bubble encoding constant already used by the pipeline registers.
- One sub-module, `sat_counter`. It is parameterized by width, has asynchronous active-high reset and an `inc` input, and saturates. It is instantiated three times.
- The FSM, watchdog and priority logic live in the top module.

## Test plan
- Reset, then `hazard_detected` = 1 for 2 cycles → `pc_freeze`, `if_id_freeze` and `id_ex_bubble` are 1 in both cycles; all other controls are 0; `stall_cycles` = 2.
- `branch_taken` and `hazard_detected` both 1 for one cycle → `if_id_flush` = `id_ex_bubble` = 1; no freeze is asserted; `flush_events` = 1; `stall_cycles` is unchanged.
- `mem_access` = 1 with `mem_ready` rising on the 4th cycle, `branch_taken` held throughout → all freezes are 1 for 3 cycles; in cycle 4 the flush is applied with no freeze; `mem_wait_cycles` = 3; FSM back in RUN.
- `MEM_TIMEOUT` = 4, `mem_ready` held at 0 → `mem_timeout_err` rises after 4 wait cycles and stays 1 after `mem_ready` = 1, until `rst`.
- `CNT_W` = 3, with the hazard held for 10 cycles → `stall_cycles` reaches 7 and holds there.
- `rst` pulsed during MEM_WAIT → outputs go to 0 asynchronously; after release, a zero-wait access causes no freeze.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared types and constants for the pipeline stall controller
package pipeline_stall_controller_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int DEFAULT_CNT_W = 32;

    // Encoding the pipeline registers load when a stage is turned into a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - freeze/flush/bubble control for the five-stage pipeline
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_freeze,
    output logic             id_ex_bubble,
    output logic             ex_mem_freeze,
    output logic             mem_wb_freeze,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              mem_freeze;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stall_inc;
    logic              flush_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_freeze = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_access && !mem_ready) begin
                    state_nxt  = ST_MEM_WAIT;
                    mem_freeze = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = ST_RUN;
                end else begin
                    mem_freeze = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Memory freeze outranks the branch flush: the frozen instructions are re-presented on release
    always_comb begin
        pc_freeze     = 1'b0;
        if_id_freeze  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_freeze  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_freeze = 1'b0;
        mem_wb_freeze = 1'b0;
        if (!rst) begin
            if (mem_freeze) begin
                pc_freeze     = 1'b1;
                if_id_freeze  = 1'b1;
                id_ex_freeze  = 1'b1;
                ex_mem_freeze = 1'b1;
                mem_wb_freeze = 1'b1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (hazard_detected) begin
                pc_freeze    = 1'b1;
                if_id_freeze = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Holding wait_cnt at zero in RUN gives a clean count on every MEM_WAIT entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                wait_cnt <= '0;
            end else if (!mem_ready && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if ((state == ST_MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_MAX)) begin
                mem_timeout_err <= 1'b1;
            end
        end
    end

    assign stall_inc = !mem_freeze && !branch_taken && hazard_detected;
    assign flush_inc = !mem_freeze && branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_events)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_freeze),
        .count (mem_wait_cycles)
    );

endmodule
